rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
Write-port controller for the register file. Arbitrates two writeback sources onto the register file's single write port: source A is the ALU result path, source B is the load-return path. Each source uses a valid/ready handshake, and the block drives a registered rf_wr_en/rf_wr_addr/rf_din triple. It also keeps a pending-write scoreboard per register, so the issue stage can detect RAW and WAW hazards against writes still in flight.

Parameters:
D_WIDTH, 32, data width of register contents
ADDRESS_WIDTH, 5, register index width; 2**ADDRESS_WIDTH registers
STARVE_LIMIT, 4, consecutive denied cycles after which source B gets priority (range 1..15)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
a_valid  in  1  source A (ALU) has a write
a_ready  out  1  source A write accepted this cycle
a_addr  in  ADDRESS_WIDTH  source A destination register
a_data  in  D_WIDTH  source A write data
b_valid  in  1  source B (load) has a write
b_ready  out  1  source B write accepted this cycle
b_addr  in  ADDRESS_WIDTH  source B destination register
b_data  in  D_WIDTH  source B write data
alloc_en  in  1  issue stage reserves a destination register
alloc_addr  in  ADDRESS_WIDTH  register being reserved
rs1_addr  in  ADDRESS_WIDTH  issue-stage source operand 1
rs2_addr  in  ADDRESS_WIDTH  issue-stage source operand 2
rd_addr  in  ADDRESS_WIDTH  issue-stage destination, used for the WAW check
hazard  out  1  combinational stall request to the issue stage
pending  out  2**ADDRESS_WIDTH  scoreboard vector; bit i set means a write to register i is in flight
rf_wr_en  out  1  register file write enable
rf_wr_addr  out  ADDRESS_WIDTH  register file write address
rf_din  out  D_WIDTH  register file write data

Behaviour:
- Reset (asynchronous, rst=1):
  - rf_wr_en=0, rf_wr_addr=0, rf_din=0.
  - pending=0, starvation counter=0.
  - a_ready and b_ready are forced to 0 while rst is high.
  - Reset mid-operation discards any accepted but unretired write.
- Arbitration (combinational, at most one grant per cycle):
  - Default priority is A over B.
  - If the starvation counter equals STARVE_LIMIT and b_valid=1, B is granted even when a_valid=1.
  - a_ready = grant_A and b_ready = grant_B. Ready depends on valid; sources must not make valid depend on ready.
  - A handshake completes on a cycle with valid & ready. Sources hold valid, addr and data stable until accepted.
- Starvation counter (4-bit, saturating at STARVE_LIMIT):
  - Increments on a cycle with b_valid=1 and B not granted.
  - Clears when B is granted or b_valid=0.
- Write stage (one-cycle latency):
  - An accepted write appears on rf_wr_en/rf_wr_addr/rf_din in the next cycle, for exactly one cycle.
  - With no acceptance, rf_wr_en=0 next cycle; rf_wr_addr and rf_din hold their last values.
  - A write accepted with addr=0 completes its handshake but yields rf_wr_en=0. The x0 write is dropped and the address/data outputs are not updated.
- Scoreboard:
  - Set: on posedge with alloc_en=1 and alloc_addr!=0, pending[alloc_addr] is set.
  - Clear: on posedge with rf_wr_en=1, pending[rf_wr_addr] is cleared.
  - Set and clear of the same register in the same cycle: set wins, because the new reservation is in flight.
  - alloc_en with alloc_addr=0 is ignored; pending[0] is always 0.
  - Sources must not write a register that was not reserved; such a write still goes through and clears nothing extra.
- Hazard (combinational, from current pending only, no bypass):
  - hazard = pending[rs1_addr] | pending[rs2_addr] | pending[rd_addr].
  - Terms whose address is 0 are masked.
  - The rd term blocks WAW reallocation, so at most one reservation per register exists.
- Timing: register file samples writes on negedge clk, so a write retired in cycle N is readable combinationally from cycle N+1 onward. pending clears at the same posedge.

Test Plan:
- Reset: assert rst mid-write with rf_wr_en=1 and pending[5]=1 -> rf_wr_en, pending and the counter go to 0 immediately, without waiting for a clk edge.
- Single write: alloc r7; next cycle a_valid=1, a_addr=7, a_data=0xDEADBEEF -> a_ready=1 that cycle; next cycle rf_wr_en=1, rf_wr_addr=7, rf_din=0xDEADBEEF; pending[7]=0 after that edge.
- Contention: a_valid and b_valid both held high (STARVE_LIMIT=4) -> A granted 4 consecutive cycles, B granted on the 5th, then the counter is 0 and A is granted again.
- x0 handling: alloc_en with alloc_addr=0 -> pending unchanged. b_valid=1, b_addr=0 -> b_ready=1, next-cycle rf_wr_en=0, and rf_wr_addr/rf_din keep their prior values.
- Hazards: pending[3]=1 -> hazard=1 for rs1=3, rs2=3 or rd=3; hazard=0 for rs1=rs2=rd=0 or for unrelated registers.
- Same-cycle set and clear: retiring a write to r9 while alloc_en=1, alloc_addr=9 -> pending[9]=1 after the edge; a further write to r9 clears it.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback sources, issue-stage scoreboard queries and register-file write port
interface rf_wb_arbiter_if #(
    parameter int D_WIDTH       = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                          a_valid;
    logic                          a_ready;
    logic [ADDRESS_WIDTH-1:0]      a_addr;
    logic [D_WIDTH-1:0]            a_data;
    logic                          b_valid;
    logic                          b_ready;
    logic [ADDRESS_WIDTH-1:0]      b_addr;
    logic [D_WIDTH-1:0]            b_data;
    logic                          alloc_en;
    logic [ADDRESS_WIDTH-1:0]      alloc_addr;
    logic [ADDRESS_WIDTH-1:0]      rs1_addr;
    logic [ADDRESS_WIDTH-1:0]      rs2_addr;
    logic [ADDRESS_WIDTH-1:0]      rd_addr;
    logic                          hazard;
    logic [2**ADDRESS_WIDTH-1:0]   pending;
    logic                          rf_wr_en;
    logic [ADDRESS_WIDTH-1:0]      rf_wr_addr;
    logic [D_WIDTH-1:0]            rf_din;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
               alloc_en, alloc_addr, rs1_addr, rs2_addr, rd_addr,
        input  a_ready, b_ready, hazard, pending, rf_wr_en, rf_wr_addr, rf_din
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
               alloc_en, alloc_addr, rs1_addr, rs2_addr, rd_addr,
        output a_ready, b_ready, hazard, pending, rf_wr_en, rf_wr_addr, rf_din
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates ALU and load writebacks onto one register-file write port with a pending-write scoreboard
module rf_wb_arbiter #(
    parameter int D_WIDTH       = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int STARVE_LIMIT  = 4
) (
    input logic            clk,
    input logic            rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int         N     = 2**ADDRESS_WIDTH;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]               starve;
    logic                     grant_a, grant_b, wr_fire;
    logic [ADDRESS_WIDTH-1:0] wr_addr, wr_addr_q;
    logic [D_WIDTH-1:0]       wr_data, wr_data_q;
    logic                     wr_en_q;
    logic [N-1:0]             pend, pend_next;

    // A wins by default; a starved B takes the port once the counter hits the limit
    always_comb begin
        grant_b = bus.b_valid && (!bus.a_valid || starve == LIMIT);
        grant_a = bus.a_valid && !grant_b;
        wr_addr = grant_b ? bus.b_addr : bus.a_addr;
        wr_data = grant_b ? bus.b_data : bus.a_data;
        wr_fire = (grant_a || grant_b) && wr_addr != '0;
    end

    assign bus.a_ready    = grant_a && !rst;
    assign bus.b_ready    = grant_b && !rst;
    assign bus.rf_wr_en   = wr_en_q;
    assign bus.rf_wr_addr = wr_addr_q;
    assign bus.rf_din     = wr_data_q;
    assign bus.pending    = pend;
    assign bus.hazard     = (bus.rs1_addr != '0 && pend[bus.rs1_addr]) ||
                            (bus.rs2_addr != '0 && pend[bus.rs2_addr]) ||
                            (bus.rd_addr  != '0 && pend[bus.rd_addr]);

    // retiring write clears its bit first so a same-cycle reservation of that register survives
    always_comb begin
        pend_next = pend;
        if (wr_en_q) pend_next[wr_addr_q] = 1'b0;
        if (bus.alloc_en && bus.alloc_addr != '0) pend_next[bus.alloc_addr] = 1'b1;
        pend_next[0] = 1'b0;
    end

    // count consecutive denied B cycles, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve <= '0;
        else if (bus.b_valid && !grant_b) starve <= (starve == LIMIT) ? starve : starve + 4'd1;
        else starve <= '0;
    end

    // one-cycle write stage; x0 writes are dropped and leave address/data untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= wr_fire;
            if (wr_fire) begin
                wr_addr_q <= wr_addr;
                wr_data_q <= wr_data;
            end
        end
    end

    // pending-write scoreboard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= '0;
        else pend <= pend_next;
    end
endmodule
